// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frames, 5..9 data bits,
// optional parity, 1/1.5/2 stop bits, CTS gating and break.
module uart_tx_fifo #(
  parameter int DIV_WIDTH = 16,
  parameter int FIFO_AW   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           cfg_data_bits,
  input  logic                 cfg_parity_en,
  input  logic [1:0]           cfg_parity_mode,
  input  logic [1:0]           cfg_stop_bits,
  input  logic [DIV_WIDTH-1:0] cfg_divisor,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [8:0]           wr_data,
  input  logic                 cts_n,
  input  logic                 brk_req,
  output logic                 tx,
  output logic                 busy,
  output logic [FIFO_AW:0]     fifo_level
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] LV1 = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] P1 = FIFO_AW'(1);
  localparam logic [DIV_WIDTH:0] C1 = (DIV_WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK, MARK
  } state_t;

  state_t state;

  logic [8:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wptr;
  logic [FIFO_AW-1:0]   rptr;
  logic [FIFO_AW:0]     level;
  logic                 push;
  logic                 pop;
  logic                 can_start;
  logic [8:0]           head;

  logic [DIV_WIDTH:0]   cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic [1:0]           stop_q;
  logic                 par_en_q;
  logic                 par_q;
  logic [3:0]           left;
  logic [8:0]           sh;
  logic                 bit_end;

  logic [3:0]           nbits;
  logic [8:0]           mask;
  logic                 even;
  logic                 par_new;
  logic [DIV_WIDTH:0]   half;
  logic [DIV_WIDTH:0]   stop_load;

  assign wr_ready   = (level != FULL);
  assign push       = wr_valid && wr_ready;
  assign head       = mem[rptr];
  assign fifo_level = level;
  assign busy       = (state != IDLE) || (level != '0);
  assign can_start  = (level != '0) && !cts_n;
  assign bit_end    = (cnt == '0);

  // Frame start in IDLE, or chained straight out of STOP/MARK.
  assign pop = can_start && !brk_req &&
               ((state == IDLE) ||
                (((state == STOP) || (state == MARK)) && bit_end));

  assign nbits = (cfg_data_bits > 3'd4) ? 4'd9
               : {1'b0, cfg_data_bits} + 4'd5;
  assign mask  = ~(9'h1FF << nbits);
  assign even  = ^(head & mask);

  always_comb begin
    par_new = 1'b0;
    unique case (cfg_parity_mode)
      2'b00: par_new = 1'b0;
      2'b01: par_new = ~even;
      2'b10: par_new = even;
      2'b11: par_new = 1'b1;
    endcase
  end

  // Stop length minus one, in clk cycles.
  assign half = ({1'b0, div_q} + C1) >> 1;

  always_comb begin
    stop_load = {1'b0, div_q};
    unique case (stop_q)
      2'b00:   stop_load = {1'b0, div_q};
      2'b01:   stop_load = {1'b0, div_q} + half;
      default: stop_load = {div_q, 1'b1};
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + P1;
      if (pop)  rptr <= rptr + P1;
      unique case ({push, pop})
        2'b10:   level <= level + LV1;
        2'b01:   level <= level - LV1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      cnt      <= '0;
      div_q    <= '0;
      stop_q   <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      left     <= '0;
      sh       <= '0;
    end else begin
      // Line level follows the state one cycle later.
      unique case (state)
        START, BREAK: tx <= 1'b0;
        DATA:         tx <= sh[0];
        PARITY:       tx <= par_q;
        default:      tx <= 1'b1;
      endcase

      if (pop) begin
        state    <= START;
        cnt      <= {1'b0, cfg_divisor};
        div_q    <= cfg_divisor;
        stop_q   <= cfg_stop_bits;
        par_en_q <= cfg_parity_en;
        par_q    <= par_new;
        left     <= nbits;
        sh       <= head & mask;
      end else begin
        unique case (state)
          IDLE: begin
            if (brk_req) state <= BREAK;
          end
          START: begin
            if (bit_end) begin
              state <= DATA;
              cnt   <= {1'b0, div_q};
            end else begin
              cnt <= cnt - C1;
            end
          end
          DATA: begin
            if (bit_end) begin
              sh   <= sh >> 1;
              left <= left - 4'd1;
              if (left == 4'd1) begin
                if (par_en_q) begin
                  state <= PARITY;
                  cnt   <= {1'b0, div_q};
                end else begin
                  state <= STOP;
                  cnt   <= stop_load;
                end
              end else begin
                cnt <= {1'b0, div_q};
              end
            end else begin
              cnt <= cnt - C1;
            end
          end
          PARITY: begin
            if (bit_end) begin
              state <= STOP;
              cnt   <= stop_load;
            end else begin
              cnt <= cnt - C1;
            end
          end
          STOP, MARK: begin
            if (bit_end) begin
              state <= brk_req ? BREAK : IDLE;
            end else begin
              cnt <= cnt - C1;
            end
          end
          BREAK: begin
            if (!brk_req) begin
              state <= MARK;
              cnt   <= {1'b0, div_q};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed and random frames checked
// against a bit-list frame model and a word queue.
`define CHK(tag, o, e) \
  begin \
    vectors++; \
    assert ((o) === (e)) else begin \
      miscompares++; \
      $error("FAIL %s: got %0h, want %0h", tag, o, e); \
    end \
  end

module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cfg_data_bits;
  logic        cfg_parity_en;
  logic [1:0]  cfg_parity_mode;
  logic [1:0]  cfg_stop_bits;
  logic [15:0] cfg_divisor;
  logic        wr_valid;
  logic        wr_ready;
  logic [8:0]  wr_data;
  logic        cts_n;
  logic        brk_req;
  logic        tx;
  logic        busy;
  logic [4:0]  fifo_level;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] q[$];

  uart_tx_fifo dut (
    .clk(clk), .rst(rst),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity_en(cfg_parity_en),
    .cfg_parity_mode(cfg_parity_mode),
    .cfg_stop_bits(cfg_stop_bits),
    .cfg_divisor(cfg_divisor),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .cts_n(cts_n),
    .brk_req(brk_req), .tx(tx), .busy(busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic set_cfg(input int b, input int pe,
                         input int pm, input int sb,
                         input int dv);
    cfg_data_bits   = 3'(b);
    cfg_parity_en   = 1'(pe);
    cfg_parity_mode = 2'(pm);
    cfg_stop_bits   = 2'(sb);
    cfg_divisor     = 16'(dv);
  endtask

  task automatic rand_cfg();
    set_cfg($urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(1, 3));
  endtask

  // Expected line level per clk cycle for one frame.
  task automatic model(input logic [8:0] d, input int nb,
                       input int pe, input int pm,
                       input int sb, input int dv,
                       output logic [255:0] w,
                       output int len);
    int p, pos, ones, sc;
    logic pb;
    p = dv + 1;
    pos = 0;
    ones = 0;
    w = '0;
    for (int k = 0; k < p; k++) begin
      w[pos] = 1'b0; pos++;
    end
    for (int b = 0; b < nb; b++) begin
      if (d[b]) ones++;
      for (int k = 0; k < p; k++) begin
        w[pos] = d[b]; pos++;
      end
    end
    if (pe != 0) begin
      case (pm)
        0: pb = 1'b0;
        1: pb = (ones % 2) == 0;
        2: pb = (ones % 2) == 1;
        default: pb = 1'b1;
      endcase
      for (int k = 0; k < p; k++) begin
        w[pos] = pb; pos++;
      end
    end
    if (sb == 0) sc = p;
    else if (sb == 1) sc = p + p / 2;
    else sc = 2 * p;
    for (int k = 0; k < sc; k++) begin
      w[pos] = 1'b1; pos++;
    end
    len = pos;
  endtask

  task automatic push(input logic [8:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
    q.push_back(d);
  endtask

  task automatic wait_low(input int lim, output int waited);
    waited = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        waited = i;
        break;
      end
    end
    vectors++;
    if (waited < 0) begin
      miscompares++;
      $error("FAIL wait_low: tx not low within %0d clk", lim);
    end
  endtask

  // Called on the first start-bit sample; ends on the last stop sample.
  task automatic capture(input int brk_at, input bit scr,
                         input string tag);
    logic [255:0] e, o;
    logic [8:0] d;
    int len, nb;
    d = (q.size() > 0) ? q.pop_front() : 9'h000;
    nb = (cfg_data_bits > 3'd4) ? 9 : int'(cfg_data_bits) + 5;
    model(d, nb, int'(cfg_parity_en), int'(cfg_parity_mode),
          int'(cfg_stop_bits), int'(cfg_divisor), e, len);
    o = '0;
    o[0] = tx;
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      o[i] = tx;
      if (i == 1) `CHK("busy_in_frame", busy, 1'b1)
      if (i == brk_at) brk_req = 1'b1;
      if (scr && i == 2) rand_cfg();
    end
    `CHK(tag, o, e)
  endtask

  initial begin
    int w, n0, n1;
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_data = '0;
    cts_n = 1'b0;
    brk_req = 1'b0;
    set_cfg(3, 0, 0, 0, 3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({tx, busy, fifo_level, wr_ready} !== {1'b1, 1'b0, 5'd0, 1'b1}) begin
      miscompares++;
      $error("FAIL reset state: tx=%b busy=%b lvl=%0d rdy=%b",
             tx, busy, fifo_level, wr_ready);
    end
    `CHK("rst_tx", tx, 1'b1)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_level", fifo_level, 5'd0)
    `CHK("rst_ready", wr_ready, 1'b1)

    // 8N1, divisor 3
    push(9'h055);
    wait_low(6, w);
    `CHK("latency", w, 2)
    capture(-1, 0, "frame_8n1");
    @(negedge clk);
    `CHK("idle_busy", busy, 1'b0)
    `CHK("idle_tx", tx, 1'b1)

    // 7E2 then 7O2, divisor 1
    set_cfg(2, 1, 2, 2, 1);
    push(9'h041);
    wait_low(6, w);
    capture(-1, 0, "frame_7e2");
    set_cfg(2, 1, 1, 2, 1);
    push(9'h041);
    wait_low(6, w);
    capture(-1, 0, "frame_7o2");

    // 9O1 and 5-bit truncation
    set_cfg(4, 1, 1, 0, 1);
    push(9'h1FF);
    wait_low(6, w);
    capture(-1, 0, "frame_9o1");
    set_cfg(0, 1, 1, 0, 1);
    push(9'h1FF);
    wait_low(6, w);
    capture(-1, 0, "frame_5o1");

    // Random frames; config scrambled mid-frame
    for (int r = 0; r < 10; r++) begin
      rand_cfg();
      push(9'($urandom));
      wait_low(6, w);
      `CHK("rnd_start", w, 2)
      capture(-1, 1, "frame_rnd");
    end

    // CTS hold-off, full FIFO, back-to-back drain
    set_cfg(3, 0, 0, 0, 1);
    cts_n = 1'b1;
    for (int i = 0; i < 16; i++) push(9'($urandom));
    `CHK("full_ready", wr_ready, 1'b0)
    `CHK("full_level", fifo_level, 5'd16)
    wr_valid = 1'b1;
    wr_data = 9'h0AA;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (5) @(negedge clk);
    `CHK("full_level2", fifo_level, 5'd16)
    `CHK("cts_tx", tx, 1'b1)
    cts_n = 1'b0;
    wait_low(6, w);
    `CHK("cts_start", w, 2)
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        @(negedge clk);
        `CHK("b2b_start", tx, 1'b0)
      end
      capture(-1, 0, "frame_b2b");
    end
    `CHK("drain_level", fifo_level, 5'd0)

    // 1.5 stop, break mid-data, mark then next word
    set_cfg(3, 0, 0, 1, 3);
    push(9'h0C3);
    push(9'h05A);
    wait_low(6, w);
    capture(10, 0, "frame_brk");
    n0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b0) n0++;
    end
    `CHK("brk_low", n0, 20)
    `CHK("brk_level", fifo_level, 5'd1)
    brk_req = 1'b0;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx === 1'b1) n1++;
      else if (n1 > 0) break;
      else n0++;
    end
    `CHK("mark_len", n1, 4)
    capture(-1, 0, "frame_after_mark");

    // Reset mid-frame with words queued
    set_cfg(3, 0, 0, 0, 3);
    for (int i = 0; i < 5; i++) push(9'($urandom));
    wait_low(6, w);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    `CHK("rst_mid_tx", tx, 1'b1)
    `CHK("rst_mid_level", fifo_level, 5'd0)
    `CHK("rst_mid_busy", busy, 1'b0)
    rst = 1'b0;
    q.delete();
    n0 = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) n0++;
    end
    `CHK("rst_quiet", n0, 0)

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
